fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 167 ++++++++++++++++
 tb/tb_fetch_unit.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//   Instruction fetch stage with an IF/ID pipeline register. Fetch is started
//   by a single-cycle start pulse, advances one word per cycle and honours
//   decode stalls and branch redirects, with redirect taking priority. It stops
//   permanently when the configured halt word is fetched. Only reset clears
//   the halt.
//
// Parameters
//   RESET_PC    : PC value loaded by reset
//   HALT_WORD   : instruction encoding that stops fetch
//
// Ports
//   clk         in   system clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   start       in   one-cycle pulse, leaves IDLE
//   stall       in   hold request from the hazard unit
//   redirect    in   taken branch/jump: load redirect_pc and flush IF/ID
//   redirect_pc in   32-bit redirect target (loaded unmasked)
//   pc_out      out  current fetch address to instruction memory
//   instr_in    in   instruction memory word for pc_out (combinational)
//   if_id_instr out  registered instruction for decode
//   if_id_pc4   out  registered fetch PC + 4 for if_id_instr
//   if_id_valid out  if_id_instr holds a real instruction (0 = bubble)
//   halted      out  fetch stopped on HALT_WORD
// -----------------------------------------------------------------------------
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] pc_out,
  input  logic [31:0] instr_in,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc4,
  output logic        if_id_valid,
  output logic        halted
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic [31:0] r_pc4;
  logic        r_valid;
  logic        r_halted;

  logic [31:0] w_pc_nxt;
  logic [31:0] w_instr_nxt;
  logic [31:0] w_pc4_nxt;
  logic        w_valid_nxt;
  logic        w_halted_nxt;

  logic        w_fetch;      // a real fetch slot: running, no redirect, no stall
  logic        w_is_halt;
  logic [31:0] w_pc_plus4;   // wraps modulo 2^32 with no carry out

  assign w_fetch    = (r_state == S_RUN) && !redirect && !stall;
  assign w_is_halt  = (instr_in == HALT_WORD);
  assign w_pc_plus4 = r_pc + 32'd4;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // the pre-edge values of its peers; blocking here would create order-
  // dependent simulation and mismatch synthesis.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every combinational output gets a default assignment first, so no
  // path through the case leaves it unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_RUN;
      S_RUN:   if (w_fetch && w_is_halt) w_state_nxt = S_HALT;
      S_HALT:  w_state_nxt = S_HALT;   // only reset leaves HALT
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output / datapath next values
  // Redirect wins over stall. A fetched halt word is not forwarded, and the PC
  // stays parked on the halt word's address.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_pc_nxt     = r_pc;
    w_instr_nxt  = r_instr;
    w_pc4_nxt    = r_pc4;
    w_valid_nxt  = r_valid;
    w_halted_nxt = r_halted;
    unique case (r_state)
      S_IDLE: begin
        w_valid_nxt = 1'b0;
      end
      S_RUN: begin
        if (redirect) begin
          w_pc_nxt    = redirect_pc;
          w_instr_nxt = 32'h0;
          w_valid_nxt = 1'b0;
        end else if (!stall) begin
          if (w_is_halt) begin
            w_valid_nxt  = 1'b0;
            w_halted_nxt = 1'b1;
          end else begin
            w_instr_nxt = instr_in;
            w_pc4_nxt   = w_pc_plus4;
            w_valid_nxt = 1'b1;
            w_pc_nxt    = w_pc_plus4;
          end
        end
      end
      S_HALT: begin
        w_valid_nxt  = 1'b0;
        w_halted_nxt = 1'b1;
      end
      default: begin
        w_valid_nxt = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc     <= RESET_PC;
      r_instr  <= 32'h0;
      r_pc4    <= 32'h0;
      r_valid  <= 1'b0;
      r_halted <= 1'b0;
    end else begin
      r_pc     <= w_pc_nxt;
      r_instr  <= w_instr_nxt;
      r_pc4    <= w_pc4_nxt;
      r_valid  <= w_valid_nxt;
      r_halted <= w_halted_nxt;
    end
  end

  assign pc_out      = r_pc;
  assign if_id_instr = r_instr;
  assign if_id_pc4   = r_pc4;
  assign if_id_valid = r_valid;
  assign halted      = r_halted;

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
//   Directed bench for fetch_unit. A small behavioural model predicts PC and
//   IF/ID contents. Each predicted capture is pushed to a scoreboard queue
//   when the fetch cycle is driven, and popped when the edge has happened.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {M_IDLE, M_RUN, M_HALT} mstate_t;
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] pc_out;
  logic [31:0] instr_in;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc4;
  logic        if_id_valid;
  logic        halted;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state
  mstate_t     m_state;
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic [31:0] m_pc4;
  logic        m_valid;
  logic        m_halted;
  exp_t        sb[$];

  fetch_unit #(.RESET_PC(RESET_PC), .HALT_WORD(HALT_WORD)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .pc_out      (pc_out),
    .instr_in    (instr_in),
    .if_id_instr (if_id_instr),
    .if_id_pc4   (if_id_pc4),
    .if_id_valid (if_id_valid),
    .halted      (halted)
  );

  always #5 clk = ~clk;

  // Instruction memory contents
  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    case (addr)
      32'h0000_0000: mem_word = 32'h0000_0000;
      32'h0000_0004: mem_word = 32'h8C21_0001;
      32'h0000_0008: mem_word = 32'h8C42_0002;
      32'h0000_0028: mem_word = HALT_WORD;
      default:       mem_word = addr + 32'h1000_0000;
    endcase
  endfunction

  always_comb instr_in = mem_word(pc_out);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".pc_out"},      pc_out,      m_pc);
    check({tag, ".if_id_instr"}, if_id_instr, m_instr);
    check({tag, ".if_id_pc4"},   if_id_pc4,   m_pc4);
    check({tag, ".if_id_valid"}, {31'b0, if_id_valid}, {31'b0, m_valid});
    check({tag, ".halted"},      {31'b0, halted},      {31'b0, m_halted});
  endtask

  task automatic model_reset();
    m_state  = M_IDLE;
    m_pc     = RESET_PC;
    m_instr  = 32'h0;
    m_pc4    = 32'h0;
    m_valid  = 1'b0;
    m_halted = 1'b0;
    sb.delete();
  endtask

  // One clock cycle: drive inputs, predict, clock, then compare.
  task automatic step(input string tag, input logic s, input logic st,
                      input logic rd, input logic [31:0] rpc);
    logic [31:0] w;
    exp_t        e;
    start = s; stall = st; redirect = rd; redirect_pc = rpc;
    case (m_state)
      M_IDLE: if (s) m_state = M_RUN;
      M_RUN: begin
        if (rd) begin
          m_pc = rpc; m_valid = 1'b0; m_instr = 32'h0;
        end else if (!st) begin
          w = mem_word(m_pc);
          if (w == HALT_WORD) begin
            m_state = M_HALT; m_halted = 1'b1; m_valid = 1'b0;
          end else begin
            sb.push_back('{instr: w, pc4: m_pc + 32'd4});
            m_valid = 1'b1;
            m_pc    = m_pc + 32'd4;
          end
        end
      end
      default: ;
    endcase
    @(posedge clk);
    #1;
    if (sb.size() > 0) begin
      e       = sb.pop_front();
      m_instr = e.instr;
      m_pc4   = e.pc4;
    end
    check_all(tag);
  endtask

  initial begin
    // Reset
    rst_n = 1'b0; start = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    #2 rst_n = 1'b1;

    // IDLE ignores stall/redirect; nothing moves without start
    step("idle_ignore", 1'b0, 1'b1, 1'b1, 32'h0000_0040);
    step("idle_quiet",  1'b0, 1'b0, 1'b0, 32'h0);

    // Start: RUN, PC unchanged, no capture yet
    step("start", 1'b1, 1'b0, 1'b0, 32'h0);
    check("start.pc_lit", pc_out, 32'h0);

    // Sequential fetch of words at 0 and 4
    step("fetch0", 1'b0, 1'b0, 1'b0, 32'h0);
    check("fetch0.instr_lit", if_id_instr, 32'h0000_0000);
    check("fetch0.pc4_lit",   if_id_pc4,   32'h4);
    step("fetch4", 1'b1, 1'b0, 1'b0, 32'h0);   // start in RUN is ignored
    check("fetch4.instr_lit", if_id_instr, 32'h8C21_0001);
    check("fetch4.pc_lit",    pc_out,      32'h8);

    // Stall for three cycles at pc 8
    for (int i = 0; i < 3; i++) step("stall", 1'b0, 1'b1, 1'b0, 32'h0);
    check("stall.pc_lit",    pc_out,      32'h8);
    check("stall.instr_lit", if_id_instr, 32'h8C21_0001);
    step("fetch8", 1'b0, 1'b0, 1'b0, 32'h0);
    check("fetch8.instr_lit", if_id_instr, 32'h8C42_0002);
    check("fetch8.pc4_lit",   if_id_pc4,   32'hC);
    step("fetchC", 1'b0, 1'b0, 1'b0, 32'h0);

    // Redirect wins over stall
    step("redir_stall", 1'b0, 1'b1, 1'b1, 32'h0000_001C);
    check("redir.pc_lit",    pc_out,      32'h1C);
    check("redir.valid_lit", {31'b0, if_id_valid}, 32'h0);
    step("fetch1C", 1'b0, 1'b0, 1'b0, 32'h0);
    check("fetch1C.instr_lit", if_id_instr, 32'h1000_001C);

    // Unaligned target is not masked
    step("redir_unal", 1'b0, 1'b0, 1'b1, 32'h0000_0102);
    check("unal.pc_lit", pc_out, 32'h102);
    step("fetch102", 1'b0, 1'b0, 1'b0, 32'h0);

    // PC wrap
    step("redir_wrap", 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
    step("wrap", 1'b0, 1'b0, 1'b0, 32'h0);
    check("wrap.pc_lit",  pc_out,    32'h0);
    check("wrap.pc4_lit", if_id_pc4, 32'h0);

    // Halt at 0x28
    step("redir_24", 1'b0, 1'b0, 1'b1, 32'h0000_0024);
    step("fetch24", 1'b0, 1'b0, 1'b0, 32'h0);
    step("halt", 1'b0, 1'b0, 1'b0, 32'h0);
    check("halt.pc_lit",     pc_out,            32'h28);
    check("halt.halted_lit", {31'b0, halted},   32'h1);
    step("halt_start", 1'b1, 1'b0, 1'b0, 32'h0);
    step("halt_redir", 1'b0, 1'b1, 1'b1, 32'h0000_0080);
    step("halt_free",  1'b0, 1'b0, 1'b0, 32'h0);
    check("halt_hold.pc_lit", pc_out, 32'h28);

    // Async reset from HALT, then back to IDLE waiting for start
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check_all("rst_halt");
    #1 rst_n = 1'b1;
    step("post_rst", 1'b0, 1'b0, 1'b1, 32'h0000_0010);

    // Run again, then async reset between edges during RUN
    step("restart", 1'b1, 1'b0, 1'b0, 32'h0);
    step("rf0", 1'b0, 1'b0, 1'b0, 32'h0);
    step("rf4", 1'b0, 1'b1, 1'b0, 32'h0);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check_all("rst_run");
    #1 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) step("idle_wait", 1'b0, 1'b0, 1'b0, 32'h0);

    check("scoreboard_empty", sb.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog so the run always terminates
  initial begin
    #20000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
